// File: rtl/mem_ctrl_pkg.sv
// Shared constants and FSM state encoding for the memory controller
// and the RAM placed beside it.
package mem_ctrl_pkg;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 32;
    localparam int RAM_DEPTH = 512;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_CAP,
        DONE
    } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// MAR/MDR memory controller between the control unit and a synchronous RAM.
// One access at a time; the RAM strobes are decoded from the state register only.
module mem_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata_out,
    output logic              addr_err,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    import mem_ctrl_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] wdr_q;
    logic [DATA_W-1:0] mdr_q;
    logic              addr_err_q;
    logic              accept;
    logic              addr_bad;

    assign accept   = (state_q == IDLE) && req;
    assign addr_bad = (addr_in[31:ADDR_W] != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mar_q      <= '0;
            wdr_q      <= '0;
            mdr_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mar_q      <= addr_in[ADDR_W-1:0];
                wdr_q      <= wdata_in;
                addr_err_q <= addr_bad;
            end
            // RAM output is registered, so read data is stable during RD_CAP
            if (state_q == RD_CAP) begin
                mdr_q <= ram_data_out;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        done      = 1'b0;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    if (addr_bad) begin
                        state_d = DONE;
                    end else if (we) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR: begin
                ram_write = 1'b1;
                state_d   = DONE;
            end
            RD: begin
                ram_read = 1'b1;
                state_d  = RD_CAP;
            end
            RD_CAP: begin
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdata_out   = mdr_q;
    assign addr_err    = addr_err_q;
    assign ram_address = mar_q;
    assign ram_data_in = wdr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural synchronous RAM alongside it.
module tb_mem_ctrl;

    import mem_ctrl_pkg::*;

    logic              clock;
    logic              reset_n;
    logic              req;
    logic              we;
    logic [31:0]       addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rdata_out;
    logic              addr_err;
    logic              ram_read;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;

    logic [DATA_W-1:0] mem [RAM_DEPTH];

    int checks = 0;
    int errors = 0;

    mem_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .we          (we),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .ready       (ready),
        .done        (done),
        .rdata_out   (rdata_out),
        .addr_err    (addr_err),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .ram_address (ram_address),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_write) mem[ram_address] <= ram_data_in;
        if (ram_read)  ram_data_out     <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
        mem[149]   = 32'h0000_00FF;
        mem[16]    = 32'h1234_5678;
        mem[9'h30] = 32'h1111_1111;
        ram_data_out = '0;
        reset_n  = 1'b0;
        req      = 1'b0;
        we       = 1'b0;
        addr_in  = '0;
        wdata_in = '0;

        // Reset state
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_strobes", {ram_read, ram_write}, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_rdata", rdata_out, 0);
        chk("rst_mar", ram_address, 0);
        chk("rst_wdr", ram_data_in, 0);

        // Read word 149, accepted on the first edge after reset release
        @(negedge clock);
        reset_n = 1'b1;
        req = 1'b1; we = 1'b0; addr_in = 32'h95;
        step();
        req = 1'b0;
        chk("rd_c1_ready", ready, 0);
        chk("rd_c1_read", ram_read, 1);
        chk("rd_c1_write", ram_write, 0);
        chk("rd_c1_addr", ram_address, 149);
        chk("rd_c1_done", done, 0);
        step();
        chk("rd_c2_read", ram_read, 0);
        chk("rd_c2_done", done, 0);
        step();
        chk("rd_c3_done", done, 1);
        chk("rd_c3_rdata", rdata_out, 32'h0000_00FF);
        step();
        chk("rd_c4_ready", ready, 1);
        chk("rd_c4_done", done, 0);

        // Write to top legal address
        req = 1'b1; we = 1'b1; addr_in = 32'h1FF; wdata_in = 32'hDEAD_BEEF;
        step();
        req = 1'b0;
        chk("wr_c1_write", ram_write, 1);
        chk("wr_c1_read", ram_read, 0);
        chk("wr_c1_addr", ram_address, 9'h1FF);
        chk("wr_c1_data", ram_data_in, 32'hDEAD_BEEF);
        chk("wr_c1_done", done, 0);
        step();
        chk("wr_c2_done", done, 1);
        chk("wr_c2_write", ram_write, 0);
        step();
        chk("wr_c3_ready", ready, 1);

        // Read back top address
        req = 1'b1; we = 1'b0; addr_in = 32'h1FF;
        step();
        req = 1'b0;
        chk("rb_c1_read", ram_read, 1);
        step();
        step();
        chk("rb_c3_done", done, 1);
        chk("rb_c3_rdata", rdata_out, 32'hDEAD_BEEF);
        chk("rb_c3_err", addr_err, 0);
        step();

        // First out-of-range address
        req = 1'b1; we = 1'b0; addr_in = 32'h200;
        step();
        req = 1'b0;
        chk("err_c1_done", done, 1);
        chk("err_c1_flag", addr_err, 1);
        chk("err_c1_strobes", {ram_read, ram_write}, 0);
        chk("err_c1_rdata", rdata_out, 32'hDEAD_BEEF);
        step();
        chk("err_c2_ready", ready, 1);
        chk("err_c2_done", done, 0);
        chk("err_c2_flag", addr_err, 1);
        step();
        chk("err_c3_flag", addr_err, 1);

        // Next valid request clears the flag; stray req during RD_CAP is ignored
        req = 1'b1; we = 1'b0; addr_in = 32'h10;
        step();
        req = 1'b0;
        chk("clr_flag", addr_err, 0);
        chk("clr_read", ram_read, 1);
        step();
        req = 1'b1; we = 1'b1; addr_in = 32'h20; wdata_in = 32'hCAFE_0000;
        step();
        req = 1'b0;
        chk("ign_done", done, 1);
        chk("ign_mar", ram_address, 9'h10);
        chk("ign_rdata", rdata_out, 32'h1234_5678);
        step();
        chk("ign_ready", ready, 1);
        chk("ign_done2", done, 0);
        chk("ign_mar2", ram_address, 9'h10);
        step();
        chk("ign_done3", done, 0);
        chk("ign_strobes", {ram_read, ram_write}, 0);

        // Reset in the middle of a write
        req = 1'b1; we = 1'b1; addr_in = 32'h30; wdata_in = 32'hA5A5_A5A5;
        step();
        req = 1'b0;
        chk("abort_pre_write", ram_write, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_write", ram_write, 0);
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        step();
        chk("abort_done2", done, 0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        chk("abort_done3", done, 0);
        chk("abort_mar", ram_address, 0);
        chk("abort_wdr", ram_data_in, 0);
        req = 1'b1; we = 1'b0; addr_in = 32'h30;
        step();
        req = 1'b0;
        step();
        step();
        chk("abort_mem_done", done, 1);
        chk("abort_mem", rdata_out, 32'h1111_1111);
        step();

        // Back-to-back writes with req held
        req = 1'b1; we = 1'b1; addr_in = 32'h40; wdata_in = 32'h0000_0001;
        step();
        addr_in = 32'h41; wdata_in = 32'h0000_0002;
        chk("b2b_c1_write", ram_write, 1);
        chk("b2b_c1_addr", ram_address, 9'h40);
        chk("b2b_c1_ready", ready, 0);
        step();
        chk("b2b_c2_ready", ready, 0);
        chk("b2b_c2_done", done, 1);
        step();
        chk("b2b_c3_ready", ready, 1);
        chk("b2b_c3_write", ram_write, 0);
        step();
        req = 1'b0;
        chk("b2b_c4_write", ram_write, 1);
        chk("b2b_c4_addr", ram_address, 9'h41);
        chk("b2b_c4_data", ram_data_in, 32'h0000_0002);
        step();
        chk("b2b_c5_done", done, 1);
        step();
        req = 1'b1; we = 1'b0; addr_in = 32'h40;
        step();
        req = 1'b0;
        step();
        step();
        chk("b2b_rd_done", done, 1);
        chk("b2b_rd_data", rdata_out, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 9, RAM word-address width; DATA_W, default 32, data width.
REQ-002 clock  in  1  system clock; all state changes on the rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 req  in  1  access request from control unit; sampled only while ready=1.
REQ-005 we  in  1  1 selects write, 0 selects read; sampled with req.
REQ-006 addr_in  in  32  byte-agnostic word address from the datapath (MAR source).
REQ-007 wdata_in  in  DATA_W  write data from the datapath (MDR source).
REQ-008 ready  out  1  controller idle and able to accept req.
REQ-009 done  out  1  one-cycle pulse marking completion of an accepted access.
REQ-010 rdata_out  out  DATA_W  MDR contents; the last successfully read word.
REQ-011 addr_err  out  1  last accepted access had addr_in[31:ADDR_W] != 0.
REQ-012 ram_read, ram_write  out  1 each  strobes to the synchronous RAM.
REQ-013 ram_address  out  ADDR_W  RAM word address (MAR low bits).
REQ-014 ram_data_in  out  DATA_W  write data to the RAM.
REQ-015 ram_data_out  in  DATA_W  RAM registered read data, valid one cycle after the address edge.

Function
REQ-016 FSM states SHALL be IDLE, WR, RD, RD_CAP, DONE; ready=1 only in IDLE.
REQ-017 In IDLE with req=1: MAR <= addr_in[ADDR_W-1:0], WDR <= wdata_in, addr_err <= (addr_in[31:ADDR_W] != 0).
REQ-018 From IDLE on accepted req: addr error -> DONE; else we=1 -> WR; else -> RD.
REQ-019 WR: ram_write=1, ram_address=MAR, ram_data_in=WDR for exactly one cycle; next state DONE.
REQ-020 RD: ram_read=1, ram_address=MAR for one cycle; next state RD_CAP.
REQ-021 RD_CAP: MDR <= ram_data_out at the end of the cycle; next state DONE.
REQ-022 DONE: done=1 for one cycle; next state IDLE; rdata_out valid whenever done=1 after a read.
REQ-023 Latency from accepting edge: write done in 2nd following cycle; read done in 3rd following cycle; error done in 1st following cycle.
REQ-024 Throughput: new req accepted no earlier than the cycle after DONE (write every 3 cycles, read every 4).
REQ-025 req while ready=0 SHALL be ignored, not queued; requester holds req until accepted.
REQ-026 Address error: no RAM strobe asserted, MDR unchanged; addr_err stays set until the next accepted req.
REQ-027 ram_read and ram_write SHALL never be asserted simultaneously, and each SHALL be a pure decode of the state register (glitch-free, no combinational path from req).
REQ-028 ram_address SHALL hold MAR in all states; ram_data_in SHALL hold WDR in all states.
REQ-029 Address ADDR_W'h1FF is legal; 32'h0000_0200 is an error (boundary).

Reset
REQ-030 reset_n=0 SHALL immediately force state IDLE, ready=1, done=0, ram_read=0, ram_write=0, addr_err=0, MAR=0, WDR=0, MDR=0.
REQ-031 Reset asserted in WR or RD SHALL deassert the RAM strobe asynchronously; the access is aborted and no done is produced.
REQ-032 First req is accepted on the first rising edge with reset_n=1.

Structure
REQ-033 Package mem_ctrl_pkg SHALL hold the state enum, ADDR_W=9, DATA_W=32, RAM_DEPTH=512.
REQ-034 Single flat module; no sub-module; the RAM is instantiated alongside it, not inside it.

Verification
REQ-035 RAM preloaded word 149 = 32'h000000FF; read addr_in=32'h95 -> ram_read one cycle, done 3 cycles after accept, rdata_out=32'h000000FF.
REQ-036 Write addr 32'h1FF data 32'hDEADBEEF, then read 32'h1FF -> ram_write one cycle, done 2 cycles after accept, read returns 32'hDEADBEEF.
REQ-037 Read addr 32'h200 -> no strobe, addr_err=1, done 1 cycle after accept, rdata_out unchanged; next valid req clears addr_err.
REQ-038 req pulsed high during RD_CAP with a different address -> ignored, MAR unchanged, one done only.
REQ-039 reset_n low mid-WR -> ram_write falls without a clock edge, state IDLE, no done.
REQ-040 Back-to-back writes with req held high -> accepts spaced exactly 3 cycles, ready low between.
